// File: rtl/keccak_seq_pkg.sv
// keccak_seq_pkg: shared definitions for the KetchupPeripheral AXI4-Lite sequencer
//   register offsets, digest mode encodings, digest length per mode, FSM states
package keccak_seq_pkg;

    localparam int ADDR_W = 7;

    localparam logic [ADDR_W-1:0] REG_CONTROL = 7'h00;
    localparam logic [ADDR_W-1:0] REG_STATUS  = 7'h04;
    localparam logic [ADDR_W-1:0] REG_INPUT   = 7'h08;
    localparam logic [ADDR_W-1:0] REG_COMMAND = 7'h0C;
    localparam logic [ADDR_W-1:0] REG_OUTPUT  = 7'h10;

    typedef enum logic [1:0] {
        MODE_512 = 2'd0,
        MODE_384 = 2'd1,
        MODE_256 = 2'd2,
        MODE_224 = 2'd3
    } mode_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST,
        S_WAIT_FIRST,
        S_CTRL_BODY,
        S_WAIT_IN,
        S_WR_IN,
        S_CTRL_LAST,
        S_WR_LAST,
        S_POLL,
        S_POLL_WAIT,
        S_RD_OUT,
        S_PRESENT
    } state_t;

    // Number of 32-bit digest words produced for each mode
    function automatic logic [4:0] words_for_mode(input mode_t m);
        return m == MODE_512 ? 5'd16 : m == MODE_384 ? 5'd12 : m == MODE_256 ? 5'd8 : 5'd7;
    endfunction

endpackage

// File: rtl/axi_lite_master_xfer.sv
// axi_lite_master_xfer: single-transaction AXI4-Lite master engine
//   req/we/addr/wdata : transaction request, sampled when the engine is free
//   done              : one-cycle pulse when the response handshake completes
//   rdata/resp_err    : read data and nonzero-response flag, valid with done
//   M_AXI_*           : AXI4-Lite master channels
module axi_lite_master_xfer
    import keccak_seq_pkg::*;
(
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic [2:0]        M_AXI_AWPROT,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [31:0]       M_AXI_WDATA,
    output logic [3:0]        M_AXI_WSTRB,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic [2:0]        M_AXI_ARPROT,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [31:0]       M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);

    logic r_busy, r_done, r_err;

    assign done         = r_done;
    assign resp_err     = r_err;
    assign M_AXI_AWPROT = 3'd0;
    assign M_AXI_ARPROT = 3'd0;
    assign M_AXI_WSTRB  = 4'hF;

    // r_done blocks a restart in the completion cycle, while the caller's
    // request is still asserted from the state it is about to leave
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            rdata         <= '0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (req && !r_busy && !r_done) begin
                r_busy <= 1'b1;
                if (we) begin
                    M_AXI_AWADDR  <= addr;
                    M_AXI_WDATA   <= wdata;
                    M_AXI_AWVALID <= 1'b1;
                    M_AXI_WVALID  <= 1'b1;
                    M_AXI_BREADY  <= 1'b1;
                end else begin
                    M_AXI_ARADDR  <= addr;
                    M_AXI_ARVALID <= 1'b1;
                    M_AXI_RREADY  <= 1'b1;
                end
            end
            if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
            if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
            if (M_AXI_ARVALID && M_AXI_ARREADY) M_AXI_ARVALID <= 1'b0;
            if (M_AXI_BREADY && M_AXI_BVALID) begin
                M_AXI_BREADY <= 1'b0;
                r_busy       <= 1'b0;
                r_done       <= 1'b1;
                r_err        <= |M_AXI_BRESP;
            end
            if (M_AXI_RREADY && M_AXI_RVALID) begin
                M_AXI_RREADY <= 1'b0;
                r_busy       <= 1'b0;
                r_done       <= 1'b1;
                r_err        <= |M_AXI_RRESP;
                rdata        <= M_AXI_RDATA;
            end
        end
    end

endmodule

// File: rtl/keccak_axi_sequencer.sv
// keccak_axi_sequencer: autonomous AXI4-Lite driver for the KetchupPeripheral SHA-3 core
//   cmd_*   : hash command (digest mode) handshake
//   in_*    : message word stream, first byte in [31:24], in_bytes on last beat
//   out_*   : digest word stream, most significant word first
//   busy    : not idle; error: sticky bus-error / poll-timeout flag
//   M_AXI_* : AXI4-Lite master to the peripheral's slave port
module keccak_axi_sequencer
    import keccak_seq_pkg::*;
#(
    parameter int POLL_GAP   = 4,
    parameter int POLL_LIMIT = 65535
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    input  logic [1:0]        in_bytes,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_last,
    output logic              busy,
    output logic              error,
    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic [2:0]        M_AXI_AWPROT,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [31:0]       M_AXI_WDATA,
    output logic [3:0]        M_AXI_WSTRB,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic [2:0]        M_AXI_ARPROT,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [31:0]       M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);

    state_t            r_state, w_next;
    mode_t             r_mode;
    logic [1:0]        r_bytes;
    logic [31:0]       r_data, r_out, r_polls, r_gap;
    logic [3:0]        r_word;
    logic              r_err, r_first;
    logic              w_req, w_we, w_done, w_resp_err, w_timeout, w_last_word;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata, w_rdata;

    assign cmd_ready   = r_state == S_IDLE;
    assign busy        = r_state != S_IDLE;
    assign error       = r_err;
    assign out_valid   = r_state == S_PRESENT;
    assign out_data    = r_out;
    assign w_last_word = {1'b0, r_word} == words_for_mode(r_mode) - 5'd1;
    assign out_last    = out_valid && w_last_word;
    assign w_timeout   = r_state == S_POLL && w_done && !w_rdata[0] && POLL_LIMIT != 0 &&
                         r_polls + 32'd1 >= 32'(POLL_LIMIT);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) r_state <= S_IDLE;
        else                r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_req    = 1'b0;
        w_we     = 1'b1;
        w_addr   = REG_COMMAND;
        w_wdata  = 32'd1;
        in_ready = 1'b0;
        case (r_state)
            S_IDLE:       if (cmd_valid) w_next = S_RST;
            S_RST: begin
                w_req = 1'b1;
                if (w_done) w_next = S_WAIT_FIRST;
            end
            // Peek only: the first beat decides whether a body CONTROL is needed
            S_WAIT_FIRST: if (in_valid) w_next = in_last ? S_CTRL_LAST : S_CTRL_BODY;
            S_CTRL_BODY: begin
                w_req   = 1'b1;
                w_addr  = REG_CONTROL;
                w_wdata = {26'd0, r_mode, 4'd0};
                if (w_done) w_next = S_WAIT_IN;
            end
            S_WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) w_next = in_last ? S_CTRL_LAST : S_WR_IN;
            end
            S_WR_IN: begin
                w_req   = 1'b1;
                w_addr  = REG_INPUT;
                w_wdata = r_data;
                if (w_done) w_next = S_WAIT_IN;
            end
            // A single-beat message is still pending here; its byte count is taken
            // straight from the input in the same cycle the beat is accepted
            S_CTRL_LAST: begin
                w_req    = 1'b1;
                in_ready = r_first;
                w_addr   = REG_CONTROL;
                w_wdata  = {26'd0, r_mode, 2'b01, r_first ? in_bytes : r_bytes};
                if (w_done) w_next = S_WR_LAST;
            end
            S_WR_LAST: begin
                w_req   = 1'b1;
                w_addr  = REG_INPUT;
                w_wdata = r_data;
                if (w_done) w_next = S_POLL;
            end
            S_POLL: begin
                w_req  = 1'b1;
                w_we   = 1'b0;
                w_addr = REG_STATUS;
                if (w_done) w_next = w_rdata[0] ? S_RD_OUT : w_timeout ? S_IDLE :
                                     POLL_GAP == 0 ? S_POLL : S_POLL_WAIT;
            end
            S_POLL_WAIT:  w_next = r_gap == 32'd0 ? S_POLL : S_POLL_WAIT;
            S_RD_OUT: begin
                w_req  = 1'b1;
                w_we   = 1'b0;
                w_addr = REG_OUTPUT + {1'b0, r_word, 2'b00};
                if (w_done) w_next = S_PRESENT;
            end
            S_PRESENT:    if (out_ready) w_next = w_last_word ? S_IDLE : S_RD_OUT;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_mode  <= MODE_512;
            r_bytes <= 2'd0;
            r_data  <= '0;
            r_out   <= '0;
            r_polls <= '0;
            r_gap   <= '0;
            r_word  <= '0;
            r_err   <= 1'b0;
            r_first <= 1'b0;
        end else begin
            if (r_state == S_IDLE && cmd_valid) begin
                r_mode  <= mode_t'(cmd_mode);
                r_err   <= 1'b0;
                r_word  <= '0;
                r_polls <= '0;
            end
            if ((w_done && w_resp_err) || w_timeout) r_err <= 1'b1;
            if (r_state == S_WAIT_FIRST && in_valid && in_last) r_first <= 1'b1;
            if (in_valid && in_ready) begin
                r_data  <= in_data;
                r_bytes <= in_bytes;
                r_first <= 1'b0;
            end
            if (r_state == S_POLL && w_done) r_polls <= r_polls + 32'd1;
            if (r_state == S_POLL && w_next == S_POLL_WAIT) r_gap <= 32'(POLL_GAP - 1);
            else if (r_state == S_POLL_WAIT) r_gap <= r_gap - 32'd1;
            if (r_state == S_RD_OUT && w_done) r_out <= w_rdata;
            if (r_state == S_PRESENT && out_ready) r_word <= r_word + 4'd1;
        end
    end

    axi_lite_master_xfer u_xfer (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .req           (w_req),
        .we            (w_we),
        .addr          (w_addr),
        .wdata         (w_wdata),
        .done          (w_done),
        .rdata         (w_rdata),
        .resp_err      (w_resp_err),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWPROT  (M_AXI_AWPROT),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARPROT  (M_AXI_ARPROT),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

endmodule
